sprite_vram_banked: RTL and testbench

Parametrised banked sprite line memory for the sprite pipeline. The block stores sprite pixel data as NUM_BANKS parallel banks. The write side accepts one BANK_WIDTH-bit pixel word per cycle with byte strobes. The read side returns one full sprite line (NUM_BANKS×BANK_WIDTH bits) per request with fixed latency, and a built-in clear engine zeroes the whole array without CPU writes.

---
 rtl/sprite_vram_pkg.sv | 24 ++
 rtl/sprite_vram_bank.sv | 49 ++++
 rtl/sprite_vram_banked.sv | 168 ++++++++++++++++
 tb/tb_sprite_vram_banked.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_vram_pkg.sv
// Shared definitions for the banked sprite line memory.
//   - clear engine state encoding
//   - default geometry constants
//   - bank_lsb(): bit offset of a bank's word inside a read line (bank 0 is most significant)
package sprite_vram_pkg;

  localparam int unsigned NumBanksDef  = 16;
  localparam int unsigned BankWidthDef = 16;
  localparam int unsigned LineDepthDef = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } clear_state_e;

  // LSB position of bank 'bank' within a NUM_BANKS*BANK_WIDTH line.
  function automatic int unsigned bank_lsb(input int unsigned bank,
                                           input int unsigned num_banks,
                                           input int unsigned bank_width);
    return (num_banks - 1 - bank) * bank_width;
  endfunction

endpackage

// File: rtl/sprite_vram_bank.sv
// One bank of the sprite line memory: simple dual-port RAM, LINE_DEPTH x BANK_WIDTH,
// byte write enables, read-first on a same-address collision.
// Ports:
//   clk, reset_n          clock, async active-low reset (output register only)
//   we, wstrb, waddr, wdata   write port; wstrb bit k enables byte k
//   re, raddr             read port; rdata updates one cycle after re and holds otherwise
//   rdata                 registered read data (resets to 0; array contents do not)
module sprite_vram_bank #(
  parameter int unsigned BANK_WIDTH = 16,
  parameter int unsigned LINE_DEPTH = 4096,
  localparam int unsigned LINE_AW   = $clog2(LINE_DEPTH),
  localparam int unsigned STRB_W    = BANK_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [LINE_AW-1:0]    waddr,
  input  logic [BANK_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [LINE_AW-1:0]    raddr,
  output logic [BANK_WIDTH-1:0] rdata
);

  logic [BANK_WIDTH-1:0] mem [LINE_DEPTH];
  logic [BANK_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wstrb[k]) begin
          mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  // Non-blocking update of mem means a colliding read sees the old word (read-first).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_vram_banked.sv
// Banked sprite line memory. NUM_BANKS parallel banks; writes are one bank word per cycle
// with byte strobes, reads return a whole line (bank 0 in the most significant word).
// A clear engine zeroes every line, one line per cycle, then pulses clear_done.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data/wr_strb   write channel; wr_addr = {line, bank}
//   rd_req/rd_addr                     read request, never stalled
//   rd_data/rd_valid                   line response; rd_data holds when rd_valid is low
//   clear_start/clear_busy/clear_done  clear engine control and status
// Build option: VRAM_OUTPUT_REG_EN adds an output register stage (read latency 2).
module sprite_vram_banked
  import sprite_vram_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = NumBanksDef,
  parameter int unsigned BANK_WIDTH = BankWidthDef,
  parameter int unsigned LINE_DEPTH = LineDepthDef,
  localparam int unsigned LINE_AW   = $clog2(LINE_DEPTH),
  localparam int unsigned BANK_AW   = $clog2(NUM_BANKS),
  localparam int unsigned WR_AW     = LINE_AW + BANK_AW,
  localparam int unsigned STRB_W    = BANK_WIDTH / 8,
  localparam int unsigned LINE_W    = NUM_BANKS * BANK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WR_AW-1:0]      wr_addr,
  input  logic [BANK_WIDTH-1:0] wr_data,
  input  logic [STRB_W-1:0]     wr_strb,
  input  logic                  rd_req,
  input  logic [LINE_AW-1:0]    rd_addr,
  output logic [LINE_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done
);

  clear_state_e       state_q;
  logic [LINE_AW-1:0] clr_line_q;
  logic               busy_q, done_q, wr_ready_q;
  logic               rd_valid1_q;

  logic               clearing;
  logic               wr_fire;
  logic [BANK_AW-1:0] wr_bank;
  logic [LINE_AW-1:0] wr_line;

  logic [STRB_W-1:0]     bank_wstrb;
  logic [LINE_AW-1:0]    bank_waddr;
  logic [BANK_WIDTH-1:0] bank_wdata;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [BANK_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [LINE_W-1:0]     line_data;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      clr_line_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_q    <= StClear;
            clr_line_q <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        StClear: begin
          // Counter wraps to 0 naturally since LINE_DEPTH is a power of two.
          clr_line_q <= clr_line_q + 1'b1;
          if (clr_line_q == LINE_AW'(LINE_DEPTH - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          wr_ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign clearing   = (state_q == StClear);
  assign wr_ready   = wr_ready_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

  // ---------------------------------------------------------------------------
  // Bank write port: clear engine owns all banks while clearing
  // ---------------------------------------------------------------------------
  assign wr_fire    = wr_valid && wr_ready_q;
  assign wr_bank    = wr_addr[BANK_AW-1:0];
  assign wr_line    = wr_addr[WR_AW-1:BANK_AW];
  assign bank_wstrb = clearing ? '1 : wr_strb;
  assign bank_waddr = clearing ? clr_line_q : wr_line;
  assign bank_wdata = clearing ? '0 : wr_data;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = clearing || (wr_fire && (wr_bank == BANK_AW'(b)));

    sprite_vram_bank #(
      .BANK_WIDTH (BANK_WIDTH),
      .LINE_DEPTH (LINE_DEPTH)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (bank_we[b]),
      .wstrb   (bank_wstrb),
      .waddr   (bank_waddr),
      .wdata   (bank_wdata),
      .re      (rd_req),
      .raddr   (rd_addr),
      .rdata   (bank_rdata[b])
    );

    assign line_data[bank_lsb(b, NUM_BANKS, BANK_WIDTH) +: BANK_WIDTH] = bank_rdata[b];
  end

  // ---------------------------------------------------------------------------
  // Read response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid1_q <= 1'b0;
    end else begin
      rd_valid1_q <= rd_req;
    end
  end

`ifdef VRAM_OUTPUT_REG_EN
  logic [LINE_W-1:0] rd_data_q;
  logic              rd_valid2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q   <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_valid2_q <= rd_valid1_q;
      if (rd_valid1_q) begin
        rd_data_q <= line_data;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid2_q;
`else
  // Bank registers only load on rd_req, so line_data already holds between responses.
  assign rd_data  = line_data;
  assign rd_valid = rd_valid1_q;
`endif

endmodule

// File: tb/tb_sprite_vram_banked.sv
module tb_sprite_vram_banked;

`ifdef VRAM_OUTPUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [15:0]  wr_addr;
  logic [15:0]  wr_data;
  logic [1:0]   wr_strb;
  logic         rd_req;
  logic [11:0]  rd_addr;
  logic [255:0] rd_data;
  logic         rd_valid;
  logic         clear_start;
  logic         clear_busy;
  logic         clear_done;

  logic         wr_valid4;
  logic         wr_ready4;
  logic [5:0]   wr_addr4;
  logic [31:0]  wr_data4;
  logic [3:0]   wr_strb4;
  logic         rd_req4;
  logic [3:0]   rd_addr4;
  logic [127:0] rd_data4;
  logic         rd_valid4;
  logic         clear_start4;
  logic         clear_busy4;
  logic         clear_done4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sprite_vram_banked #(
    .NUM_BANKS  (16),
    .BANK_WIDTH (16),
    .LINE_DEPTH (4096)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  sprite_vram_banked #(
    .NUM_BANKS  (4),
    .BANK_WIDTH (32),
    .LINE_DEPTH (16)
  ) u_dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid4),
    .wr_ready    (wr_ready4),
    .wr_addr     (wr_addr4),
    .wr_data     (wr_data4),
    .wr_strb     (wr_strb4),
    .rd_req      (rd_req4),
    .rd_addr     (rd_addr4),
    .rd_data     (rd_data4),
    .rd_valid    (rd_valid4),
    .clear_start (clear_start4),
    .clear_busy  (clear_busy4),
    .clear_done  (clear_done4)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected line with bank b's 16-bit slice set, using the [(N-b)*W-1 -: W] mapping.
  function automatic logic [255:0] put16(input logic [255:0] line, input int b,
                                         input logic [15:0] v);
    logic [255:0] r;
    r = line;
    r[(16-b)*16-1 -: 16] = v;
    return r;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [11:0] line, input logic [3:0] bank,
                          input logic [15:0] data, input logic [1:0] strb);
    wr_valid = 1'b1;
    wr_addr  = {line, bank};
    wr_data  = data;
    wr_strb  = strb;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_strb  = '0;
  endtask

  task automatic read_line(input string tag, input logic [11:0] line,
                           output logic [255:0] data);
    rd_req  = 1'b1;
    rd_addr = line;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 1; i < RD_LAT; i++) @(negedge clk);
    check({tag, "_valid"}, 256'(rd_valid), 256'(1));
    data = rd_data;
  endtask

  // Full clear, with a write accepted in the start cycle and a blocked write during the clear.
  task automatic run_clear(input string tag);
    int busy_n = 0;
    int done_n = 0;
    int low_n  = 0;
    clear_start = 1'b1;
    wr_valid    = 1'b1;
    wr_addr     = {12'd3, 4'd1};
    wr_data     = 16'h7777;
    wr_strb     = 2'b11;
    @(negedge clk);
    clear_start = 1'b0;
    wr_valid    = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
      if (!wr_ready) low_n++;
      if (!clear_busy && busy_n > 0) break;
      if (i == 20) begin
        wr_valid = 1'b1;
        wr_addr  = {12'd7, 4'd0};
        wr_data  = 16'hFFFF;
        wr_strb  = 2'b11;
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check({tag, "_busy_cycles"}, 256'(busy_n), 256'(4097));
    check({tag, "_ready_low_cycles"}, 256'(low_n), 256'(4097));
    check({tag, "_done_pulses"}, 256'(done_n), 256'(1));
    check({tag, "_ready_after"}, 256'(wr_ready), 256'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    logic [31:0]  pat4 [4];
    int           busy_n;
    int           done_n;

    pat4[0] = 32'h1111_0000;
    pat4[1] = 32'h2222_0001;
    pat4[2] = 32'h3333_0002;
    pat4[3] = 32'h4444_0003;

    reset_n = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_req = 1'b0; rd_addr = '0; clear_start = 1'b0;
    wr_valid4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; wr_strb4 = '0;
    rd_req4 = 1'b0; rd_addr4 = '0; clear_start4 = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_valid", 256'(rd_valid), 256'(0));
    check("rst_clear_busy", 256'(clear_busy), 256'(0));
    check("rst_clear_done", 256'(clear_done), 256'(0));
    check("rst_wr_ready", 256'(wr_ready), 256'(1));
    reset_n = 1'b1;
    @(negedge clk);

    // Bring the array to a known all-zero state
    run_clear("init_clear");

    // Single full-word write then line read
    do_write(12'd5, 4'd3, 16'hBEEF, 2'b11);
    read_line("beef", 12'd5, d);
    check("beef_line", d, put16('0, 3, 16'hBEEF));
    @(negedge clk);
    check("idle_rd_valid_low", 256'(rd_valid), 256'(0));
    check("idle_rd_data_hold", rd_data, put16('0, 3, 16'hBEEF));

    // Byte strobes
    do_write(12'd9, 4'd0, 16'h1234, 2'b11);
    do_write(12'd9, 4'd0, 16'hAB00, 2'b10);
    read_line("strb_hi", 12'd9, d);
    check("strb_hi_line", d, put16('0, 0, 16'hAB34));
    do_write(12'd9, 4'd0, 16'hFFFF, 2'b00);
    read_line("strb_none", 12'd9, d);
    check("strb_none_line", d, put16('0, 0, 16'hAB34));
    do_write(12'd9, 4'd0, 16'h00CD, 2'b01);
    read_line("strb_lo", 12'd9, d);
    check("strb_lo_line", d, put16('0, 0, 16'hABCD));

    // Read-first collision
    do_write(12'd12, 4'd7, 16'h0F0F, 2'b11);
    wr_valid = 1'b1; wr_addr = {12'd12, 4'd7}; wr_data = 16'h5555; wr_strb = 2'b11;
    rd_req   = 1'b1; rd_addr = 12'd12;
    @(negedge clk);
    wr_valid = 1'b0; rd_req = 1'b0;
    for (int i = 1; i < RD_LAT; i++) @(negedge clk);
    check("collide_valid", 256'(rd_valid), 256'(1));
    check("collide_old", rd_data, put16('0, 7, 16'h0F0F));
    read_line("collide_after", 12'd12, d);
    check("collide_new", d, put16('0, 7, 16'h5555));

    // Full clear with first and last lines filled
    do_write(12'd0, 4'd0, 16'hA5A5, 2'b11);
    do_write(12'd4095, 4'd15, 16'h5A5A, 2'b11);
    read_line("fill0", 12'd0, d);
    check("fill0_line", d, put16('0, 0, 16'hA5A5));
    read_line("fill_last", 12'd4095, d);
    check("fill_last_line", d, put16('0, 15, 16'h5A5A));
    run_clear("clear");
    read_line("cleared0", 12'd0, d);
    check("cleared0_line", d, '0);
    read_line("cleared_last", 12'd4095, d);
    check("cleared_last_line", d, '0);
    read_line("blocked_wr", 12'd7, d);
    check("blocked_wr_line", d, '0);
    read_line("start_wr", 12'd3, d);
    check("start_wr_line", d, '0);

    // Reset in the middle of a clear
    do_write(12'd0, 4'd2, 16'h1357, 2'b11);
    do_write(12'd4095, 4'd2, 16'h2468, 2'b11);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (2040) @(negedge clk);
    read_line("mid0", 12'd0, d);
    check("mid0_line", d, '0);
    read_line("mid_last", 12'd4095, d);
    check("mid_last_line", d, put16('0, 2, 16'h2468));
    check("mid_busy", 256'(clear_busy), 256'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_rd_data", rd_data, '0);
    check("midrst_rd_valid", 256'(rd_valid), 256'(0));
    check("midrst_clear_busy", 256'(clear_busy), 256'(0));
    check("midrst_clear_done", 256'(clear_done), 256'(0));
    check("midrst_wr_ready", 256'(wr_ready), 256'(1));
    @(negedge clk);
    reset_n = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 4200; i++) begin
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
      @(negedge clk);
    end
    check("midrst_no_busy", 256'(busy_n), 256'(0));
    check("midrst_no_done", 256'(done_n), 256'(0));
    read_line("post0", 12'd0, d);
    check("post0_line", d, '0);
    read_line("post_last", 12'd4095, d);
    check("post_last_line", d, put16('0, 2, 16'h2468));

    // Four 32-bit banks
    clear_start4 = 1'b1;
    @(negedge clk);
    clear_start4 = 1'b0;
    repeat (20) @(negedge clk);
    check("four_ready", 256'(wr_ready4), 256'(1));
    for (int b = 0; b < 4; b++) begin
      wr_valid4 = 1'b1;
      wr_addr4  = {4'd2, 2'(b)};
      wr_data4  = pat4[b];
      wr_strb4  = 4'hF;
      @(negedge clk);
    end
    wr_valid4 = 1'b0;
    rd_req4   = 1'b1;
    rd_addr4  = 4'd2;
    @(negedge clk);
    rd_req4 = 1'b0;
    for (int i = 1; i < RD_LAT; i++) @(negedge clk);
    check("four_valid", 256'(rd_valid4), 256'(1));
    check("four_line", 256'(rd_data4),
          256'(128'h1111_0000_2222_0001_3333_0002_4444_0003));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
